ompss_axis_packet_arbiter: RTL and testbench
============================================

Name: ompss_axis_packet_arbiter

Overview:
- Shares one 64-bit OmpSs AXI-Stream master (tdata/tdest/tlast plus tid) between NUM_PORTS slave streams.
- Typical sources: per-accelerator command or ack streams that previously each had a fixed-ID tagging stage.
- Arbitration is round-robin and packet-granular: once a port is granted, it owns the output until its tlast beat is accepted.
- M_AXIS_tid carries the granted port index, so downstream logic can route replies back to the source.

Parameters:
- NUM_PORTS, 4, number of slave streams (2..16).
- ID_WIDTH, 2, width of M_AXIS_tid; must satisfy 2^ID_WIDTH >= NUM_PORTS.

Ports:
- clk  in  1  single clock.
- aresetn  in  1  asynchronous active-low reset.
- S_AXIS_tvalid  in  NUM_PORTS  per-port valid.
- S_AXIS_tready  out  NUM_PORTS  per-port ready.
- S_AXIS_tdata  in  NUM_PORTS*64  port i occupies bits [64*i+63:64*i].
- S_AXIS_tdest  in  NUM_PORTS*2  port i occupies bits [2*i+1:2*i].
- S_AXIS_tlast  in  NUM_PORTS  per-port last.
- M_AXIS_tvalid  out  1  output valid (registered).
- M_AXIS_tready  in  1  output ready.
- M_AXIS_tdata  out  64  registered data.
- M_AXIS_tdest  out  2  registered dest.
- M_AXIS_tid  out  ID_WIDTH  index of the source port for the current beat.
- M_AXIS_tlast  out  1  registered last.

Behaviour:
- Reset (async assert, sync release):
  - M_AXIS_tvalid=0; M_AXIS_tdata, tdest, tid, tlast = 0.
  - S_AXIS_tready=0 on all ports.
  - state=IDLE; last_grant=NUM_PORTS-1, so port 0 has first priority.
- Assertion mid-packet drops the in-flight packet and output register immediately. No recovery or flush is attempted.
- State machine:
  - IDLE:
    - All S_AXIS_tready=0.
    - If any S_AXIS_tvalid=1, select the first valid port searching from last_grant+1 upward, wrapping modulo NUM_PORTS.
    - Register the selection as grant and go to LOCKED next cycle.
    - Arbitration costs exactly one cycle.
  - LOCKED:
    - S_AXIS_tready[grant] = (!M_AXIS_tvalid || M_AXIS_tready). All other ready bits are 0.
    - When S_AXIS_tvalid[grant] && S_AXIS_tready[grant], load the output register from port grant (tdata, tdest, tlast) with tid=grant, and set M_AXIS_tvalid=1.
    - If that accepted beat has tlast=1: set last_grant=grant and go to IDLE.
- Output register:
  - On M_AXIS_tvalid && M_AXIS_tready with no new load in the same cycle, clear M_AXIS_tvalid.
  - Load and drain in the same cycle is allowed, giving full throughput of one beat per cycle within a packet.
  - Latency from slave acceptance to M_AXIS_tvalid is 1 cycle.
- AXIS rules:
  - M_AXIS_* must hold stable while M_AXIS_tvalid && !M_AXIS_tready.
  - The block never deasserts M_AXIS_tvalid without a handshake.
- Boundary conditions:
  - Granted port drops tvalid mid-packet: lock is held indefinitely, with no timeout and no re-arbitration.
  - Other ports asserting valid during LOCKED: ignored until return to IDLE.
  - Single-beat packet (tlast on first beat): LOCKED lasts one accepted beat, then IDLE.
  - Only one requester continuously valid: it is re-granted after each IDLE cycle, giving 1 bubble per packet on the output.
  - Output must never carry beats from two ports interleaved within a packet.
  - tid on every beat equals the port index of that packet.

Test Plan:
- Single-beat packet: port 2 sends tdata=0xDEAD_BEEF_0000_0001, tdest=1, tlast=1; M_AXIS_tready=1 -> M_AXIS beat 2 cycles after tvalid (arb + register) with tid=2, tdest=1, tlast=1. Port 2 is ready only in the LOCKED cycle.
- Simultaneous request: ports 0 and 1 each send a 3-beat packet at the same cycle -> all 3 port-0 beats (tid=0) come out contiguously, then after one idle cycle all 3 port-1 beats (tid=1). No interleaving.
- Round-robin fairness: ports 0, 1, 3 continuously valid with 2-beat packets for 12 packets -> grant order 0,1,3,0,1,3,... Each port gets exactly 4 packets.
- Backpressure: one 4-beat packet from port 1 with M_AXIS_tready toggling 1,0,0,1,... -> output data held stable while tready=0, all 4 beats delivered in order. S_AXIS_tready[1] deasserts whenever the register is full and stalled.
- Source stall: granted port 3 drops tvalid for 5 cycles mid-packet while port 0 is valid -> no port-0 beat appears until port 3's tlast is accepted.
- Reset mid-packet: assert aresetn=0 during beat 2 of a 4-beat packet -> M_AXIS_tvalid and all S_AXIS_tready go 0 within the same cycle (asynchronously). After release, port 0 is granted first when ports 0 and 2 are both valid.

Source files
------------

// File: rtl/ompss_axis_packet_arbiter_if.sv
// rtl/ompss_axis_packet_arbiter_if.sv - NUM_PORTS slave streams in, one tid-tagged OmpSs AXI-Stream out.
interface ompss_axis_packet_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2
);
  logic [NUM_PORTS-1:0]    S_AXIS_tvalid;
  logic [NUM_PORTS-1:0]    S_AXIS_tready;
  logic [NUM_PORTS*64-1:0] S_AXIS_tdata;
  logic [NUM_PORTS*2-1:0]  S_AXIS_tdest;
  logic [NUM_PORTS-1:0]    S_AXIS_tlast;

  logic                    M_AXIS_tvalid;
  logic                    M_AXIS_tready;
  logic [63:0]             M_AXIS_tdata;
  logic [1:0]              M_AXIS_tdest;
  logic [ID_WIDTH-1:0]     M_AXIS_tid;
  logic                    M_AXIS_tlast;

  // Arbiter side: owns the shared output stream and the per-port ready bits.
  modport master (
    input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tdest, S_AXIS_tlast, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tdest, M_AXIS_tid, M_AXIS_tlast
  );

  modport slave (
    output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tdest, S_AXIS_tlast, M_AXIS_tready,
    input  S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tdest, M_AXIS_tid, M_AXIS_tlast
  );
endinterface

// File: rtl/ompss_axis_packet_arbiter.sv
// rtl/ompss_axis_packet_arbiter.sv - packet-granular round-robin merge of slave streams onto one output.
module ompss_axis_packet_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       aresetn,
  ompss_axis_packet_arbiter_if.master bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;

  logic                  m_valid_q, m_valid_d;
  logic [63:0]           m_data_q, m_data_d;
  logic [1:0]            m_dest_q, m_dest_d;
  logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
  logic                  m_last_q, m_last_d;

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [ID_WIDTH:0]      rot_amt;
  int                     pick_sum;
  logic                   pick_found;
  logic [ID_WIDTH-1:0]    pick;

  logic                   out_free;
  logic                   accept;
  logic [NUM_PORTS-1:0]   s_ready;

  // Rotate requests so bit 0 is the port just after last_grant; lowest set bit wins.
  always_comb begin
    req_dbl    = {bus.S_AXIS_tvalid, bus.S_AXIS_tvalid};
    rot_amt    = {1'b0, last_grant_q} + (ID_WIDTH+1)'(1);
    req_rot    = NUM_PORTS'(req_dbl >> rot_amt);
    pick_found = 1'b0;
    pick_sum   = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = int'(last_grant_q) + 1 + k;
      end
    end
    if (pick_sum >= NUM_PORTS) begin
      pick_sum = pick_sum - NUM_PORTS;
    end
    pick = ID_WIDTH'(pick_sum);
  end

  assign out_free = !m_valid_q || bus.M_AXIS_tready;
  assign accept   = (state_q == LOCKED) && bus.S_AXIS_tvalid[grant_q] && out_free;

  always_comb begin
    s_ready = '0;
    if (state_q == LOCKED) begin
      s_ready[grant_q] = out_free;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // The lock is only released by an accepted tlast; a stalled source holds it forever.
        if (accept && bus.S_AXIS_tlast[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a load may coincide with the drain of the previous beat.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_dest_d  = m_dest_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = bus.S_AXIS_tdata[{grant_q, 6'b0} +: 64];
      m_dest_d  = bus.S_AXIS_tdest[{grant_q, 1'b0} +: 2];
      m_id_d    = grant_q;
      m_last_d  = bus.S_AXIS_tlast[grant_q];
    end else if (m_valid_q && bus.M_AXIS_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_dest_q     <= '0;
      m_id_q       <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_dest_q     <= m_dest_d;
      m_id_q       <= m_id_d;
      m_last_q     <= m_last_d;
    end
  end

  assign bus.S_AXIS_tready = s_ready;
  assign bus.M_AXIS_tvalid = m_valid_q;
  assign bus.M_AXIS_tdata  = m_data_q;
  assign bus.M_AXIS_tdest  = m_dest_q;
  assign bus.M_AXIS_tid    = m_id_q;
  assign bus.M_AXIS_tlast  = m_last_q;

endmodule

// File: tb/tb_ompss_axis_packet_arbiter.sv
// tb/tb_ompss_axis_packet_arbiter.sv - randomized bench for the packet arbiter against a round-robin packet model.
module tb_ompss_axis_packet_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [63:0]    data;
    logic [1:0]     dest;
    logic           last;
    logic [IDW-1:0] id;
  } beat_t;

  logic clk;
  logic aresetn;

  ompss_axis_packet_arbiter_if #(.NUM_PORTS(N), .ID_WIDTH(IDW)) bus ();

  ompss_axis_packet_arbiter #(.NUM_PORTS(N), .ID_WIDTH(IDW)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  beat_t src_mem [N][64];
  int    src_gap [N][64];
  int    src_cnt [N];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];
  int    errors = 0;
  int    checks = 0;

  task automatic clear_ports();
    for (int p = 0; p < N; p++) src_cnt[p] = 0;
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic idle_inputs();
    bus.S_AXIS_tvalid = '0;
    bus.S_AXIS_tdata  = '0;
    bus.S_AXIS_tdest  = '0;
    bus.S_AXIS_tlast  = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle_inputs();
    bus.M_AXIS_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  task automatic add_packet(input int p, input int len, input int max_gap);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.dest = 2'($urandom_range(3));
      b.last = (i == len - 1);
      b.id   = IDW'(p);
      src_mem[p][src_cnt[p]] = b;
      src_gap[p][src_cnt[p]] = (i == 0) ? 0 : int'($urandom_range(max_gap));
      src_cnt[p]++;
    end
  endtask

  // Whole packets leave in round-robin order among ports that still have packets queued.
  task automatic build_rr_model();
    int mptr [N];
    int last;
    int pick;
    last = N - 1;
    for (int p = 0; p < N; p++) mptr[p] = 0;
    while (1) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && mptr[(last + k) % N] < src_cnt[(last + k) % N]) pick = (last + k) % N;
      end
      if (pick < 0) break;
      while (1) begin
        exp_q.push_back(src_mem[pick][mptr[pick]]);
        mptr[pick]++;
        if (src_mem[pick][mptr[pick] - 1].last) break;
      end
      last = pick;
    end
  endtask

  task automatic drive_port(input int p, input int ptr, input int gl);
    if (ptr < src_cnt[p] && gl == 0) begin
      bus.S_AXIS_tvalid[p]         = 1'b1;
      bus.S_AXIS_tdata[p*64 +: 64] = src_mem[p][ptr].data;
      bus.S_AXIS_tdest[p*2 +: 2]   = src_mem[p][ptr].dest;
      bus.S_AXIS_tlast[p]          = src_mem[p][ptr].last;
    end else begin
      bus.S_AXIS_tvalid[p]         = 1'b0;
      bus.S_AXIS_tdata[p*64 +: 64] = '0;
      bus.S_AXIS_tdest[p*2 +: 2]   = '0;
      bus.S_AXIS_tlast[p]          = 1'b0;
    end
  endtask

  function automatic logic ready_for(input int ready_pct, input int cyc);
    if (ready_pct < 0) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return int'($urandom_range(99)) < ready_pct;
  endfunction

  // Plays the queued packets, records output beats, then compares them with exp_q.
  task automatic run_traffic(input int ready_pct, input int max_cycles);
    int        ptr [N];
    int        gap_left [N];
    logic [N-1:0] fire_s;
    logic      fire_m;
    logic      prev_stall;
    logic      done;
    beat_t     prev_beat;
    beat_t     cur;
    int        cyc;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_beat  = '0;
    for (int p = 0; p < N; p++) begin
      ptr[p]      = 0;
      gap_left[p] = (src_cnt[p] > 0) ? src_gap[p][0] : 0;
      drive_port(p, ptr[p], gap_left[p]);
    end
    bus.M_AXIS_tready = ready_for(ready_pct, cyc);
    forever begin
      @(negedge clk);
      cur    = {bus.M_AXIS_tdata, bus.M_AXIS_tdest, bus.M_AXIS_tlast, bus.M_AXIS_tid};
      fire_s = bus.S_AXIS_tvalid & bus.S_AXIS_tready;
      fire_m = bus.M_AXIS_tvalid && bus.M_AXIS_tready;
      if (prev_stall) begin
        checks++;
        if (!bus.M_AXIS_tvalid || cur !== prev_beat) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d: got valid=%0b beat=%h, need valid=1 beat=%h",
                   cyc, bus.M_AXIS_tvalid, cur, prev_beat);
        end
      end
      checks++;
      if ($countones(bus.S_AXIS_tready) > 1 ||
          (bus.M_AXIS_tvalid && !bus.M_AXIS_tready && bus.S_AXIS_tready != '0)) begin
        errors++;
        $display("FAIL ready_rule cyc=%0d: got s_ready=%b m_valid=%0b m_ready=%0b, need at most one ready and none while stalled",
                 cyc, bus.S_AXIS_tready, bus.M_AXIS_tvalid, bus.M_AXIS_tready);
      end
      if (fire_m) begin
        obs_q.push_back(cur);
        obs_cyc.push_back(cyc);
      end
      prev_stall = bus.M_AXIS_tvalid && !bus.M_AXIS_tready;
      prev_beat  = cur;
      done = (fire_s == '0) && !bus.M_AXIS_tvalid;
      for (int p = 0; p < N; p++) if (ptr[p] < src_cnt[p]) done = 1'b0;
      if (done) break;
      cyc++;
      if (cyc > max_cycles) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d beats after %0d cycles, need %0d", obs_q.size(), cyc, exp_q.size());
        break;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (fire_s[p]) begin
          ptr[p]++;
          gap_left[p] = (ptr[p] < src_cnt[p]) ? src_gap[p][ptr[p]] : 0;
        end else if (gap_left[p] > 0) begin
          gap_left[p]--;
        end
        drive_port(p, ptr[p], gap_left[p]);
      end
      bus.M_AXIS_tready = ready_for(ready_pct, cyc);
    end
    idle_inputs();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL beat_count: got %0d, need %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL beat[%0d]: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    aresetn           = 1'b0;
    bus.S_AXIS_tvalid = '1;
    bus.S_AXIS_tlast  = '1;
    bus.M_AXIS_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b, need 0", bus.M_AXIS_tvalid); end
    checks++;
    if (bus.M_AXIS_tdata !== 64'h0) begin errors++; $display("FAIL rst_m_data: got %h, need 0", bus.M_AXIS_tdata); end
    checks++;
    if (bus.M_AXIS_tdest !== 2'd0) begin errors++; $display("FAIL rst_m_dest: got %h, need 0", bus.M_AXIS_tdest); end
    checks++;
    if (bus.M_AXIS_tid !== 2'd0) begin errors++; $display("FAIL rst_m_tid: got %h, need 0", bus.M_AXIS_tid); end
    checks++;
    if (bus.M_AXIS_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b, need 0", bus.M_AXIS_tlast); end
    checks++;
    if (bus.S_AXIS_tready !== 4'b0000) begin errors++; $display("FAIL rst_s_ready: got %b, need 0000", bus.S_AXIS_tready); end
    idle_inputs();
    @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_single_beat();
    do_reset();
    bus.M_AXIS_tready        = 1'b1;
    bus.S_AXIS_tvalid[2]     = 1'b1;
    bus.S_AXIS_tdata[128 +: 64] = 64'hDEAD_BEEF_0000_0001;
    bus.S_AXIS_tdest[4 +: 2] = 2'd1;
    bus.S_AXIS_tlast[2]      = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.S_AXIS_tready !== 4'b0000) begin errors++; $display("FAIL sb_arb_ready: got %b, need 0000", bus.S_AXIS_tready); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.S_AXIS_tready !== 4'b0100) begin errors++; $display("FAIL sb_lock_ready: got %b, need 0100", bus.S_AXIS_tready); end
    checks++;
    if (bus.M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL sb_early_valid: got %b, need 0", bus.M_AXIS_tvalid); end
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b, need 1", bus.M_AXIS_tvalid); end
    checks++;
    if ({bus.M_AXIS_tdata, bus.M_AXIS_tdest, bus.M_AXIS_tid, bus.M_AXIS_tlast} !== {64'hDEAD_BEEF_0000_0001, 2'd1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL sb_beat: got data=%h dest=%0d tid=%0d last=%0b, need data=deadbeef00000001 dest=1 tid=2 last=1",
               bus.M_AXIS_tdata, bus.M_AXIS_tdest, bus.M_AXIS_tid, bus.M_AXIS_tlast);
    end
    checks++;
    if (bus.S_AXIS_tready !== 4'b0000) begin errors++; $display("FAIL sb_after_ready: got %b, need 0000", bus.S_AXIS_tready); end
    @(negedge clk);
    checks++;
    if (bus.M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL sb_drained: got %b, need 0", bus.M_AXIS_tvalid); end
  endtask

  task automatic test_simultaneous();
    int want_cyc [6] = '{2, 3, 4, 6, 7, 8};
    do_reset();
    clear_ports();
    add_packet(0, 3, 0);
    add_packet(1, 3, 0);
    build_rr_model();
    run_traffic(100, 200);
    for (int i = 0; i < 6 && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != want_cyc[i]) begin
        errors++;
        $display("FAIL sim_timing[%0d]: got cycle %0d, need %0d", i, obs_cyc[i], want_cyc[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int order [3] = '{0, 1, 3};
    int seq[$];
    int per_port [N];
    do_reset();
    clear_ports();
    for (int r = 0; r < 4; r++) begin
      add_packet(0, 2, 0);
      add_packet(1, 2, 0);
      add_packet(3, 2, 0);
    end
    build_rr_model();
    run_traffic(100, 400);
    for (int p = 0; p < N; p++) per_port[p] = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].last) begin
        seq.push_back(int'(obs_q[i].id));
        per_port[obs_q[i].id]++;
      end
    end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] != order[i % 3]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got port %0d, need %0d", i, seq[i], order[i % 3]);
      end
    end
    checks++;
    if (per_port[0] != 4 || per_port[1] != 4 || per_port[2] != 0 || per_port[3] != 4) begin
      errors++;
      $display("FAIL rr_counts: got %0d/%0d/%0d/%0d, need 4/4/0/4", per_port[0], per_port[1], per_port[2], per_port[3]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_ports();
    add_packet(1, 4, 0);
    build_rr_model();
    run_traffic(-1, 200);
  endtask

  task automatic test_source_stall();
    do_reset();
    clear_ports();
    add_packet(3, 4, 0);
    src_gap[3][2] = 5;
    add_packet(0, 2, 0);
    src_gap[0][0] = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(src_mem[3][i]);
    for (int i = 0; i < 2; i++) exp_q.push_back(src_mem[0][i]);
    run_traffic(100, 200);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.M_AXIS_tready      = 1'b1;
    bus.S_AXIS_tvalid[0]   = 1'b1;
    bus.S_AXIS_tdata[0 +: 64] = 64'h1234_5678_9ABC_DEF0;
    bus.S_AXIS_tlast[0]    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %b, need 1", bus.M_AXIS_tvalid); end
    #1 aresetn = 1'b0;
    #1;
    checks++;
    if (bus.M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, need 0", bus.M_AXIS_tvalid); end
    checks++;
    if (bus.S_AXIS_tready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b, need 0000", bus.S_AXIS_tready); end
    checks++;
    if (bus.M_AXIS_tdata !== 64'h0) begin errors++; $display("FAIL mid_rst_data: got %h, need 0", bus.M_AXIS_tdata); end
    idle_inputs();
    @(posedge clk);
    #1 aresetn = 1'b1;
    clear_ports();
    add_packet(0, 2, 1);
    add_packet(2, 2, 1);
    build_rr_model();
    run_traffic(80, 200);
    checks++;
    if (obs_q.size() == 0 || obs_q[0].id !== 2'd0) begin
      errors++;
      $display("FAIL mid_first_grant: got %0d beats first tid=%0d, need tid=0", obs_q.size(),
               (obs_q.size() > 0) ? int'(obs_q[0].id) : -1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      clear_ports();
      for (int p = 0; p < N; p++) begin
        int npk;
        npk = int'($urandom_range(3));
        for (int k = 0; k < npk; k++) add_packet(p, int'($urandom_range(1, 4)), 2);
      end
      build_rr_model();
      run_traffic(int'($urandom_range(40, 100)), 2000);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    idle_inputs();
    bus.M_AXIS_tready = 1'b0;
    clear_ports();
    test_reset();
    test_single_beat();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_source_stall();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
